vdp_ctrl: RTL and testbench

- CPU-facing register and port controller for the VDP video block (TMS9918-style).
- Decodes CPU data-port and control-port accesses.
- Holds VDP registers R0-R7 and drives the table base addresses, mode and colours into the video block.
- Sequences CPU-side VRAM accesses (auto-incrementing address, read-ahead buffer), and owns the status/frame-interrupt flag and n_int.

---
 rtl/vdp_ctrl_if.sv | 21 ++
 rtl/vdp_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vdp_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_ctrl_if.sv
// CPU I/O port bus of the VDP: data/control port strobes, write data, read data and wait.
interface vdp_ctrl_if;
  logic       io_sel;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic       io_wait;

  // CPU side drives strobes and write data
  modport master (
    output io_sel, io_wr, io_rd, io_din,
    input  io_dout, io_wait
  );

  // VDP side answers with read data and wait
  modport slave (
    input  io_sel, io_wr, io_rd, io_din,
    output io_dout, io_wait
  );
endinterface

// File: rtl/vdp_ctrl.sv
// VDP CPU-side controller: port decode, R0-R7, VRAM access sequencing and frame interrupt.
module vdp_ctrl #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              n_reset,
  vdp_ctrl_if.slave         io,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_wr,
  output logic              vram_rd,
  input  logic [7:0]        vram_rdata,
  input  logic              frame_int,
  output logic              n_int,
  output logic [1:0]        mode,
  output logic              video_on,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color
);

  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_CAPT  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_REGS-1:0][7:0]    regs_q, regs_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [7:0]                  read_buf_q, read_buf_d;
  logic                        latch_q, latch_d;
  logic [7:0]                  first_byte_q, first_byte_d;
  logic                        f_q, f_d;
  logic [ADDR_W-1:0]           vram_addr_q, vram_addr_d;
  logic [7:0]                  vram_wdata_q, vram_wdata_d;
  logic                        vram_wr_q, vram_wr_d;
  logic                        vram_rd_q, vram_rd_d;

  logic                        pf_start;
  logic [ADDR_W-1:0]           pf_addr;
  logic [ADDR_W-1:0]           setup_addr_c;

  assign setup_addr_c = ADDR_W'({io.io_din[5:0], first_byte_q});

  // Next-state: port decode in IDLE, two-cycle prefetch otherwise; frame pulse always sets F
  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    addr_d       = addr_q;
    read_buf_d   = read_buf_q;
    latch_d      = latch_q;
    first_byte_d = first_byte_q;
    f_d          = f_q;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    vram_wr_d    = 1'b0;
    vram_rd_d    = 1'b0;
    pf_start     = 1'b0;
    pf_addr      = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io.io_wr) begin
          if (io.io_sel) begin
            if (!latch_q) begin
              first_byte_d = io.io_din;
              latch_d      = 1'b1;
            end else begin
              latch_d = 1'b0;
              if (io.io_din[7]) begin
                regs_d[io.io_din[2:0]] = first_byte_q;
              end else begin
                addr_d   = setup_addr_c;
                pf_addr  = setup_addr_c;
                pf_start = ~io.io_din[6];
              end
            end
          end else begin
            vram_wr_d    = 1'b1;
            vram_addr_d  = addr_q;
            vram_wdata_d = io.io_din;
            read_buf_d   = io.io_din;
            addr_d       = addr_q + ADDR_W'(1);
            latch_d      = 1'b0;
          end
        end else if (io.io_rd) begin
          latch_d = 1'b0;
          if (io.io_sel) begin
            f_d = 1'b0;
          end else begin
            pf_start = 1'b1;
          end
        end
        if (pf_start) begin
          state_d     = ST_RD_ISSUE;
          vram_rd_d   = 1'b1;
          vram_addr_d = pf_addr;
        end
      end
      ST_RD_ISSUE: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        read_buf_d = vram_rdata;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_int) begin
      f_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      regs_q       <= '0;
      addr_q       <= '0;
      read_buf_q   <= '0;
      latch_q      <= 1'b0;
      first_byte_q <= '0;
      f_q          <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      vram_wr_q    <= 1'b0;
      vram_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      addr_q       <= addr_d;
      read_buf_q   <= read_buf_d;
      latch_q      <= latch_d;
      first_byte_q <= first_byte_d;
      f_q          <= f_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      vram_wr_q    <= vram_wr_d;
      vram_rd_q    <= vram_rd_d;
    end
  end

  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
  assign vram_wr    = vram_wr_q;
  assign vram_rd    = vram_rd_q;

  assign io.io_dout = io.io_sel ? {f_q, 7'b0} : read_buf_q;
  assign io.io_wait = (state_q != ST_IDLE);
  assign n_int      = ~(f_q & regs_q[1][5]);

  // Video configuration decoded straight from the register file
  assign mode                      = regs_q[1][4] ? 2'd0 : (regs_q[0][1] ? 2'd2 : 2'd1);
  assign video_on                  = regs_q[1][6];
  assign name_table_addr           = {regs_q[2][3:0], 10'b0};
  assign color_table_addr          = {regs_q[3], 6'b0};
  assign font_addr                 = {regs_q[4][2:0], 11'b0};
  assign sprite_attr_addr          = {regs_q[5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'b0};
  assign text_color                = regs_q[7][7:4];
  assign back_color                = regs_q[7][3:0];

  // Register bits with no decoded function in this block
  logic unused_reg_bits;
  assign unused_reg_bits = ^{regs_q[0][7:2], regs_q[0][0], regs_q[1][7], regs_q[1][3:0],
                             regs_q[2][7:4], regs_q[4][7:3], regs_q[5][7], regs_q[6][7:3]};

endmodule

// File: tb/tb_vdp_ctrl.sv
// Bench for vdp_ctrl: directed scenarios with literal expectations plus a randomized run,
// all cycles checked against a transaction-level model of the port behaviour.
module tb_vdp_ctrl;

  localparam int unsigned MEM_SZ = 16384;
  localparam int          AMASK  = 16'h3FFF;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_wr;
  logic        vram_rd;
  logic [7:0]  vram_rdata;
  logic        frame_int = 1'b0;
  logic        n_int;
  logic [1:0]  mode;
  logic        video_on;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic [3:0]  text_color, back_color;

  vdp_ctrl_if io ();

  always #5 clk = ~clk;

  vdp_ctrl #(.ADDR_W(14)) dut (
    .clk                       (clk),
    .n_reset                   (n_reset),
    .io                        (io),
    .vram_addr                 (vram_addr),
    .vram_wdata                (vram_wdata),
    .vram_wr                   (vram_wr),
    .vram_rd                   (vram_rd),
    .vram_rdata                (vram_rdata),
    .frame_int                 (frame_int),
    .n_int                     (n_int),
    .mode                      (mode),
    .video_on                  (video_on),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .text_color                (text_color),
    .back_color                (back_color)
  );

  function automatic logic [7:0] init_byte(int i);
    if (i == 32'h1234) return 8'h5A;
    if (i == 32'h1235) return 8'hC3;
    return 8'((i * 29) ^ (i >> 6) ^ 32'h3C);
  endfunction

  // VRAM behaviour: write on strobe, read data valid the cycle after vram_rd
  logic [7:0] vmem [MEM_SZ];
  initial begin
    for (int i = 0; i < int'(MEM_SZ); i++) vmem[i] = init_byte(i);
    vram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (vram_wr) vmem[vram_addr] = vram_wdata;
      if (vram_rd) vram_rdata <= vmem[vram_addr];
    end
  end

  // Reference model state (transaction level, own copy of VRAM)
  logic [7:0] mmem [MEM_SZ];
  logic [7:0] m_regs [8];
  int         m_addr, m_pf, m_busy, m_ewaddr;
  logic [7:0] m_buf, m_first, m_ewdata;
  bit         m_latch, m_f, m_ewr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  s_dout, s_vwdata;
  logic [13:0] s_vaddr;
  logic        s_wait, s_vwr, s_vrd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_addr = 0; m_pf = 0; m_busy = 0; m_ewaddr = 0;
    m_buf = 8'h00; m_first = 8'h00; m_ewdata = 8'h00;
    m_latch = 1'b0; m_f = 1'b0; m_ewr = 1'b0;
  endtask

  // Effect of one clock edge given the inputs held during the cycle that just ended
  task automatic model_step();
    logic [7:0] d;
    d = io.io_din;
    m_ewr = 1'b0;
    if (!n_reset) begin
      model_reset();
      return;
    end
    if (m_busy == 2) begin
      m_addr = (m_addr + 1) & AMASK;
      m_busy = 1;
    end else if (m_busy == 1) begin
      m_buf  = mmem[m_pf];
      m_busy = 0;
    end else if (io.io_wr) begin
      if (io.io_sel) begin
        if (!m_latch) begin
          m_first = d;
          m_latch = 1'b1;
        end else begin
          m_latch = 1'b0;
          if (d[7]) m_regs[d[2:0]] = m_first;
          else begin
            m_addr = int'(d[5:0]) * 256 + int'(m_first);
            if (!d[6]) begin m_pf = m_addr; m_busy = 2; end
          end
        end
      end else begin
        m_ewr = 1'b1; m_ewaddr = m_addr; m_ewdata = d;
        mmem[m_addr] = d;
        m_buf = d;
        m_addr = (m_addr + 1) & AMASK;
        m_latch = 1'b0;
      end
    end else if (io.io_rd) begin
      m_latch = 1'b0;
      if (io.io_sel) m_f = 1'b0;
      else begin m_pf = m_addr; m_busy = 2; end
    end
    if (frame_int) m_f = 1'b1;
  endtask

  task automatic compare_all();
    logic [7:0] exp_dout;
    int exp_mode;
    exp_dout = io.io_sel ? {m_f, 7'b0} : m_buf;
    exp_mode = m_regs[1][4] ? 0 : (m_regs[0][1] ? 2 : 1);
    check("io_dout", 32'(io.io_dout), 32'(exp_dout));
    check("io_wait", 32'(io.io_wait), 32'(m_busy != 0));
    check("vram_wr", 32'(vram_wr), 32'(m_ewr));
    if (m_ewr) begin
      check("vram_wr_addr", 32'(vram_addr), 32'(m_ewaddr));
      check("vram_wdata", 32'(vram_wdata), 32'(m_ewdata));
    end
    check("vram_rd", 32'(vram_rd), 32'(m_busy == 2));
    if (m_busy == 2) check("vram_rd_addr", 32'(vram_addr), 32'(m_pf));
    check("n_int", 32'(n_int), 32'(!(m_f && m_regs[1][5])));
    check("mode", 32'(mode), 32'(exp_mode));
    check("video_on", 32'(video_on), 32'(m_regs[1][6]));
    check("name_tbl", 32'(name_table_addr), 32'(m_regs[2] & 8'h0F) * 1024);
    check("color_tbl", 32'(color_table_addr), 32'(m_regs[3]) * 64);
    check("font", 32'(font_addr), 32'(m_regs[4] & 8'h07) * 2048);
    check("spr_attr", 32'(sprite_attr_addr), 32'(m_regs[5] & 8'h7F) * 128);
    check("spr_pat", 32'(sprite_pattern_table_addr), 32'(m_regs[6] & 8'h07) * 2048);
    check("text_color", 32'(text_color), 32'(m_regs[7]) / 16);
    check("back_color", 32'(back_color), 32'(m_regs[7]) % 16);
  endtask

  // One CPU cycle: drive, check mid-cycle, advance model at the edge
  task automatic step(input bit sel, input bit wr, input bit rd, input logic [7:0] din, input bit fint);
    io.io_sel = sel; io.io_wr = wr; io.io_rd = rd; io.io_din = din; frame_int = fint;
    @(negedge clk);
    compare_all();
    s_dout = io.io_dout; s_wait = io.io_wait; s_vwr = vram_wr; s_vrd = vram_rd;
    s_vaddr = vram_addr; s_vwdata = vram_wdata;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ctrl_wr(input logic [7:0] d); step(1'b1, 1'b1, 1'b0, d, 1'b0); endtask
  task automatic data_wr(input logic [7:0] d); step(1'b0, 1'b1, 1'b0, d, 1'b0); endtask
  task automatic data_rd();                    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0); endtask
  task automatic stat_rd(input bit fint);      step(1'b1, 1'b0, 1'b1, 8'h00, fint); endtask
  task automatic idle(input bit fint);         step(1'b0, 1'b0, 1'b0, 8'h00, fint); endtask

  initial begin
    for (int i = 0; i < int'(MEM_SZ); i++) mmem[i] = init_byte(i);
    model_reset();
    io.io_sel = 1'b0; io.io_wr = 1'b0; io.io_rd = 1'b0; io.io_din = 8'h00;
    @(posedge clk); #1;
    idle(1'b0); idle(1'b0);
    n_reset = 1'b1;
    idle(1'b0);

    // Reset state
    check("rst_mode", 32'(mode), 32'd1);
    check("rst_video_on", 32'(video_on), 32'd0);
    check("rst_n_int", 32'(n_int), 32'd1);
    check("rst_io_wait", 32'(io.io_wait), 32'd0);
    check("rst_tables", 32'({name_table_addr, color_table_addr} | {18'd0, font_addr}), 32'd0);

    // Register writes
    ctrl_wr(8'h05); ctrl_wr(8'h82);
    check("name_tbl_1400", 32'(name_table_addr), 32'h1400);
    ctrl_wr(8'hE2); ctrl_wr(8'h81);
    check("video_on_set", 32'(video_on), 32'd1);
    check("mode_after_r1", 32'(mode), 32'd1);
    ctrl_wr(8'hF4); ctrl_wr(8'h87);
    check("text_color_f", 32'(text_color), 32'd15);
    check("back_color_4", 32'(back_color), 32'd4);

    // Write setup at top of VRAM, auto-increment wraps
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(8'hAA); data_wr(8'h55);
    check("wr0_strobe", 32'(s_vwr), 32'd1);
    check("wr0_addr", 32'(s_vaddr), 32'h3FFF);
    check("wr0_data", 32'(s_vwdata), 32'hAA);
    idle(1'b0);
    check("wr1_addr", 32'(s_vaddr), 32'h0000);
    check("wr1_data", 32'(s_vwdata), 32'h55);
    data_rd();
    check("read_buf_55", 32'(s_dout), 32'h55);
    idle(1'b0); idle(1'b0);

    // Read setup and prefetch
    ctrl_wr(8'h34); ctrl_wr(8'h12);
    idle(1'b0);
    check("pf_rd", 32'(s_vrd), 32'd1);
    check("pf_addr", 32'(s_vaddr), 32'h1234);
    check("pf_wait1", 32'(s_wait), 32'd1);
    idle(1'b0);
    check("pf_wait2", 32'(s_wait), 32'd1);
    idle(1'b0);
    check("pf_wait_done", 32'(s_wait), 32'd0);
    data_rd();
    check("rd_5a", 32'(s_dout), 32'h5A);
    ctrl_wr(8'h99);
    idle(1'b0);
    data_rd();
    check("rd_c3", 32'(s_dout), 32'hC3);
    idle(1'b0); idle(1'b0);
    ctrl_wr(8'hEE); ctrl_wr(8'h87);
    check("ignored_strobe", 32'(text_color), 32'hE);

    // Frame interrupt and status reads
    idle(1'b1);
    check("n_int_low", 32'(n_int), 32'd0);
    stat_rd(1'b0);
    check("status_80", 32'(s_dout), 32'h80);
    check("n_int_cleared", 32'(n_int), 32'd1);
    stat_rd(1'b0);
    check("status_00", 32'(s_dout), 32'h00);
    idle(1'b1);
    stat_rd(1'b1);
    check("status_set_wins_rd", 32'(s_dout), 32'h80);
    check("n_int_set_wins", 32'(n_int), 32'd0);
    stat_rd(1'b0);
    check("status_still_80", 32'(s_dout), 32'h80);

    // Status read resets the control-port latch
    ctrl_wr(8'h12);
    stat_rd(1'b0);
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'h3C);
    idle(1'b0);
    check("latch_reset_addr", 32'(s_vaddr), 32'h0000);
    check("latch_reset_data", 32'(s_vwdata), 32'h3C);

    // Reset while a prefetch is in flight
    data_rd();
    check("buf_3c", 32'(s_dout), 32'h3C);
    n_reset = 1'b0;
    model_reset();
    idle(1'b0);
    check("rst_mid_wait", 32'(s_wait), 32'd0);
    check("rst_mid_rd", 32'(s_vrd), 32'd0);
    n_reset = 1'b1;
    idle(1'b0);
    data_rd();
    check("rst_mid_buf", 32'(s_dout), 32'h00);
    idle(1'b0); idle(1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] d;
      bit sel, fi;
      r   = $urandom_range(0, 99);
      fi  = ($urandom_range(0, 19) == 0);
      d   = 8'($urandom);
      sel = 1'($urandom);
      if (r < 35)      step(sel, 1'b0, 1'b0, d, fi);
      else if (r < 55) step(1'b1, 1'b1, 1'b0, d, fi);
      else if (r < 70) step(1'b0, 1'b1, 1'b0, d, fi);
      else if (r < 82) step(1'b0, 1'b0, 1'b1, d, fi);
      else if (r < 90) step(1'b1, 1'b0, 1'b1, d, fi);
      else             step(sel, 1'b1, 1'b1, d, fi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
